// File: rtl/cpu_params.sv
// rtl/cpu_params.sv - Core-wide width parameters shared by the load/store path
package cpu_params;

   localparam int CPU_ADDR_W = 32;
   localparam int CPU_LINE_W = 256;
   localparam int CPU_BEAT_W = 64;

endpackage

// File: rtl/lsu_types.sv
// rtl/lsu_types.sv - Adapter state encoding and burst beat-index constants
package lsu_types;

   import cpu_params::*;

   localparam int BEATS      = CPU_LINE_W / CPU_BEAT_W;
   localparam int BEAT_IDX_W = $clog2(BEATS);
   localparam int LINE_OFF_W = $clog2(CPU_LINE_W / 8);

   localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_DATA,
      WR_DATA,
      RESP
   } adapter_state_e;

endpackage

// File: rtl/cacheline_burst_adapter.sv
// rtl/cacheline_burst_adapter.sv - Cacheline <-> 4-beat DRAM burst adapter; optional line buffer via CACHELINE_ADAPTER_LINEBUF_EN
module cacheline_burst_adapter
   import cpu_params::*;
   import lsu_types::*;
#(
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int LINE_W = CPU_LINE_W,
   parameter int BEAT_W = CPU_BEAT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ufp_addr,
   input  logic              ufp_read,
   input  logic              ufp_write,
   input  logic [LINE_W-1:0] ufp_wdata,
   output logic [LINE_W-1:0] ufp_rdata,
   output logic              ufp_resp,
   output logic [ADDR_W-1:0] bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [ADDR_W-1:0] bmem_raddr,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);

   adapter_state_e          state_q, state_d;
   logic [BEAT_IDX_W-1:0]   cnt_q, cnt_d;
   logic                    ufp_resp_q, ufp_resp_d;
   logic [LINE_W-1:0]       ufp_rdata_q, ufp_rdata_d;
   logic                    bmem_read_q, bmem_read_d;
   logic                    bmem_write_q, bmem_write_d;
   logic [ADDR_W-1:0]       bmem_addr_q, bmem_addr_d;
   logic [BEAT_W-1:0]       bmem_wdata_q, bmem_wdata_d;

   logic [ADDR_W-1:0]       line_addr;
   logic                    raddr_hit;
   logic                    rd_done;
   logic                    wr_done;
   logic                    rd_hit;
   logic                    unused_offset;

   // The DRAM side only ever sees line-aligned addresses; the byte offset is dropped.
   assign line_addr     = {ufp_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
   assign unused_offset = ^ufp_addr[LINE_OFF_W-1:0];
   assign raddr_hit     = bmem_rvalid && (bmem_raddr == line_addr);
   assign rd_done       = (state_q == RD_DATA) && raddr_hit && (cnt_q == LAST_BEAT);
   assign wr_done       = (state_q == WR_DATA) && bmem_ready && (cnt_q == LAST_BEAT);

`ifdef CACHELINE_ADAPTER_LINEBUF_EN
   localparam int TAG_W = ADDR_W - LINE_OFF_W;

   logic              lb_valid_q, lb_valid_d;
   logic [TAG_W-1:0]  lb_tag_q, lb_tag_d;
   logic [LINE_W-1:0] lb_data_q, lb_data_d;
   logic              lb_hit;

   assign lb_hit = lb_valid_q && (lb_tag_q == ufp_addr[ADDR_W-1:LINE_OFF_W]);
   assign rd_hit = lb_hit;

   // Buffer keeps the most recently completed read line; writes to that line keep it coherent.
   always_comb begin
      lb_valid_d = lb_valid_q;
      lb_tag_d   = lb_tag_q;
      lb_data_d  = lb_data_q;
      if (rd_done) begin
         lb_valid_d = 1'b1;
         lb_tag_d   = ufp_addr[ADDR_W-1:LINE_OFF_W];
         lb_data_d  = ufp_rdata_d;
      end else if (wr_done && lb_hit) begin
         lb_data_d  = ufp_wdata;
      end
   end

   // Line buffer storage; only the valid bit needs reset to make it inert.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lb_valid_q <= 1'b0;
         lb_tag_q   <= '0;
         lb_data_q  <= '0;
      end else begin
         lb_valid_q <= lb_valid_d;
         lb_tag_q   <= lb_tag_d;
         lb_data_q  <= lb_data_d;
      end
   end
`else
   assign rd_hit = 1'b0;
`endif

   // Next-state and next-output logic; every output is registered so DRAM sees clean levels.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ufp_resp_d   = 1'b0;
      ufp_rdata_d  = ufp_rdata_q;
      bmem_read_d  = bmem_read_q;
      bmem_write_d = bmem_write_q;
      bmem_addr_d  = bmem_addr_q;
      bmem_wdata_d = bmem_wdata_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (ufp_write) begin
               state_d      = WR_DATA;
               bmem_write_d = 1'b1;
               bmem_addr_d  = line_addr;
               bmem_wdata_d = ufp_wdata[BEAT_W-1:0];
            end else if (ufp_read) begin
`ifdef CACHELINE_ADAPTER_LINEBUF_EN
               if (rd_hit) begin
                  state_d     = RESP;
                  ufp_resp_d  = 1'b1;
                  ufp_rdata_d = lb_data_q;
               end else begin
                  state_d     = RD_REQ;
                  bmem_read_d = 1'b1;
                  bmem_addr_d = line_addr;
               end
`else
               state_d     = RD_REQ;
               bmem_read_d = 1'b1;
               bmem_addr_d = line_addr;
`endif
            end
         end
         RD_REQ: begin
            if (bmem_ready) begin
               state_d     = RD_DATA;
               bmem_read_d = 1'b0;
               cnt_d       = '0;
            end
         end
         RD_DATA: begin
            if (raddr_hit) begin
               ufp_rdata_d[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
               cnt_d = cnt_q + 1'b1;
               if (rd_done) begin
                  state_d    = RESP;
                  ufp_resp_d = 1'b1;
               end
            end
         end
         WR_DATA: begin
            if (bmem_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (wr_done) begin
                  state_d      = RESP;
                  ufp_resp_d   = 1'b1;
                  bmem_write_d = 1'b0;
               end else begin
                  bmem_wdata_d = ufp_wdata[cnt_d*BEAT_W +: BEAT_W];
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control FSM and registered outputs; reset drops any partially gathered line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         ufp_resp_q   <= 1'b0;
         ufp_rdata_q  <= '0;
         bmem_read_q  <= 1'b0;
         bmem_write_q <= 1'b0;
         bmem_addr_q  <= '0;
         bmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ufp_resp_q   <= ufp_resp_d;
         ufp_rdata_q  <= ufp_rdata_d;
         bmem_read_q  <= bmem_read_d;
         bmem_write_q <= bmem_write_d;
         bmem_addr_q  <= bmem_addr_d;
         bmem_wdata_q <= bmem_wdata_d;
      end
   end

   assign ufp_rdata  = ufp_rdata_q;
   assign ufp_resp   = ufp_resp_q;
   assign bmem_addr  = bmem_addr_q;
   assign bmem_read  = bmem_read_q;
   assign bmem_write = bmem_write_q;
   assign bmem_wdata = bmem_wdata_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb/tb_cacheline_burst_adapter.sv - Randomized self-checking bench for cacheline_burst_adapter
module tb_cacheline_burst_adapter;

   logic         clk;
   logic         rst;
   logic [31:0]  ufp_addr;
   logic         ufp_read;
   logic         ufp_write;
   logic [255:0] ufp_wdata;
   logic [255:0] ufp_rdata;
   logic         ufp_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic [31:0]  bmem_raddr;
   logic [63:0]  bmem_rdata;
   logic         bmem_rvalid;

   int n_cmp = 0;
   int n_err = 0;

   // Line-buffer reference: last completed read line, kept coherent by writes.
   bit           mdl_valid = 1'b0;
   logic [26:0]  mdl_tag   = '0;
   logic [255:0] mdl_data  = '0;

   cacheline_burst_adapter dut (
      .clk         (clk),
      .rst         (rst),
      .ufp_addr    (ufp_addr),
      .ufp_read    (ufp_read),
      .ufp_write   (ufp_write),
      .ufp_wdata   (ufp_wdata),
      .ufp_rdata   (ufp_rdata),
      .ufp_resp    (ufp_resp),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // Starts and ends on a falling edge. stray_en interleaves beats for another line.
   task automatic do_read(input logic [31:0] addr, input int max_stall, input bit stray_en,
                          input bit gaps, input logic [31:0] stray_addr);
      logic [31:0]  line;
      logic [255:0] exp_line;
      logic [63:0]  d;
      int           beats;
      int           guard;
      int           stalls;
      int           iter;
      bit           early;
      line       = {addr[31:5], 5'b0};
      ufp_addr   = addr;
      ufp_read   = 1'b1;
      ufp_write  = 1'b0;
      bmem_ready = 1'b0;
      @(negedge clk);
`ifdef CACHELINE_ADAPTER_LINEBUF_EN
      if (mdl_valid && mdl_tag == addr[31:5]) begin
         chk("hit_resp", {bmem_read, ufp_resp}, 2'b01);
         chk("hit_data", ufp_rdata, mdl_data);
         ufp_read = 1'b0;
         @(negedge clk);
         chk("hit_resp_once", {bmem_read, ufp_resp}, 2'b00);
         return;
      end
`endif
      guard = 0;
      while (!bmem_read && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      chk("rd_req", bmem_read, 1'b1);
      chk("rd_addr", bmem_addr, line);
      stalls = $urandom_range(0, max_stall);
      for (int s = 0; s < stalls; s++) begin
         @(negedge clk);
         chk("rd_hold", {bmem_read, bmem_addr}, {1'b1, line});
      end
      bmem_ready = 1'b1;
      @(negedge clk);
      bmem_ready = 1'b0;
      chk("rd_single_pulse", bmem_read, 1'b0);
      exp_line = '0;
      beats    = 0;
      iter     = 0;
      early    = 1'b0;
      while (beats < 4 && iter < 64) begin
         d = rand64();
         if (stray_en && (iter % 2 == 0)) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = stray_addr;
         end else if (gaps && $urandom_range(0, 3) == 0) begin
            bmem_rvalid = 1'b0;
            bmem_raddr  = line;
         end else begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = line;
            exp_line[beats*64 +: 64] = d;
            beats++;
         end
         bmem_rdata = d;
         iter++;
         @(negedge clk);
         if (beats < 4 && ufp_resp) early = 1'b1;
      end
      bmem_rvalid = 1'b0;
      chk("rd_beats_sent", beats, 4);
      chk("rd_no_early_resp", early, 1'b0);
      chk("rd_resp", ufp_resp, 1'b1);
      chk("rd_data", ufp_rdata, exp_line);
      ufp_read = 1'b0;
      @(negedge clk);
      chk("rd_resp_once", ufp_resp, 1'b0);
      mdl_valid = 1'b1;
      mdl_tag   = addr[31:5];
      mdl_data  = exp_line;
   endtask

   // stall_beat/stall_len hold bmem_ready low on one chosen beat; others get random stalls.
   task automatic do_write(input logic [31:0] addr, input logic [255:0] w, input bit both,
                           input int stall_beat, input int stall_len, input int max_rand_stall);
      logic [31:0] line;
      int          guard;
      int          held2;
      int          stalls;
      line       = {addr[31:5], 5'b0};
      ufp_addr   = addr;
      ufp_wdata  = w;
      ufp_write  = 1'b1;
      ufp_read   = both;
      bmem_ready = 1'b0;
      @(negedge clk);
      guard = 0;
      while (!bmem_write && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      chk("wr_start", {bmem_read, bmem_write, bmem_addr}, {1'b0, 1'b1, line});
      held2 = 0;
      for (int b = 0; b < 4; b++) begin
         stalls = (b == stall_beat) ? stall_len : $urandom_range(0, max_rand_stall);
         for (int s = 0; s <= stalls; s++) begin
            chk("wr_beat", {bmem_read, bmem_write, bmem_addr, bmem_wdata},
                {1'b0, 1'b1, line, w[b*64 +: 64]});
            if (b == 2) held2++;
            bmem_ready = (s == stalls);
            @(negedge clk);
         end
      end
      bmem_ready = 1'b0;
      chk("wr_resp", {bmem_read, bmem_write, ufp_resp}, 3'b001);
      if (stall_beat == 2) chk("wr_beat2_held", held2, stall_len + 1);
      ufp_write = 1'b0;
      ufp_read  = 1'b0;
      @(negedge clk);
      chk("wr_resp_once", ufp_resp, 1'b0);
      if (mdl_valid && mdl_tag == addr[31:5]) mdl_data = w;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] rline;
      rst         = 1'b0;
      ufp_addr    = '0;
      ufp_read    = 1'b0;
      ufp_write   = 1'b0;
      ufp_wdata   = '0;
      bmem_ready  = 1'b0;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
      bmem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_ctrl", {ufp_resp, bmem_read, bmem_write}, 3'b000);
      chk("reset_bus", {bmem_addr, bmem_wdata}, '0);
      chk("reset_rdata", ufp_rdata, '0);
      rst = 1'b1;
      @(negedge clk);

      // Stray beats for another line interleaved with the real ones.
      do_read(32'h1000_0000, 2, 1'b1, 1'b1, 32'h3000_0000);
      // Write with beat 2 stalled three cycles.
      do_write(32'h2000_0047, rand256(), 1'b0, 2, 3, 0);
      // Read and write together: write wins.
      do_write(32'h2100_0010, rand256(), 1'b1, -1, 0, 1);

      // Reset in the middle of a read burst after two beats.
      a     = 32'h4000_0008;
      rline = {a[31:5], 5'b0};
      ufp_addr = a;
      ufp_read = 1'b1;
      @(negedge clk);
      bmem_ready = 1'b1;
      @(negedge clk);
      bmem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bmem_rvalid = 1'b1;
         bmem_raddr  = rline;
         bmem_rdata  = rand64() | 64'h1;
         @(negedge clk);
      end
      bmem_rvalid = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_mid_ctrl", {ufp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata}, '0);
      chk("rst_mid_rdata", ufp_rdata, '0);
      @(negedge clk);
      ufp_read = 1'b0;
      @(negedge clk);
      rst       = 1'b1;
      mdl_valid = 1'b0;
      @(negedge clk);
      do_read(a, 1, 1'b0, 1'b1, 32'h0);

      // Back-to-back beats with immediate accept.
      do_read(32'h1000_0020, 0, 1'b0, 1'b0, 32'h0);
      // Repeat read of the same line, then write it and read it back.
      do_read(32'h1000_0020, 0, 1'b0, 1'b0, 32'h0);
      do_write(32'h1000_0020, rand256(), 1'b0, -1, 0, 1);
      do_read(32'h1000_0020, 1, 1'b0, 1'b0, 32'h0);

      for (int n = 0; n < 24; n++) begin
         a = 32'h5000_0000 + ($urandom_range(0, 3) * 32) + $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 0)
            do_read(a, 2, $urandom_range(0, 1) == 1, 1'b1, {a[31:5], 5'b0} ^ 32'h2000_0000);
         else
            do_write(a, rand256(), $urandom_range(0, 3) == 0, -1, 0, 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cacheline_burst_adapter.md
CACHELINE_BURST_ADAPTER -- requirements
Module: cacheline_burst_adapter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, byte address width.
REQ-002 SHALL have parameter LINE_W, 256, cacheline width in bits.
REQ-003 SHALL have parameter BEAT_W, 64, DRAM beat width; BEATS = LINE_W/BEAT_W (4).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports ufp_addr in ADDR_W, ufp_read in 1, ufp_write in 1, ufp_wdata in LINE_W: dcache cacheline request.
REQ-007 SHALL have ports ufp_rdata out LINE_W, ufp_resp out 1: cacheline completion to dcache.
REQ-008 SHALL have ports bmem_addr out ADDR_W, bmem_read out 1, bmem_write out 1, bmem_wdata out BEAT_W: burst DRAM request.
REQ-009 SHALL have ports bmem_ready in 1, bmem_raddr in ADDR_W, bmem_rdata in BEAT_W, bmem_rvalid in 1: DRAM accept and read return.

Function
REQ-010 SHALL implement states IDLE, RD_REQ, RD_DATA, WR_DATA, RESP.
REQ-011 SHALL in IDLE, on ufp_write, go to WR_DATA; else on ufp_read, go to RD_REQ; write wins if both asserted.
REQ-012 SHALL drive bmem_addr = {ufp_addr[ADDR_W-1:5], 5'b0} whenever bmem_read or bmem_write is high.
REQ-013 SHALL in RD_REQ assert bmem_read for exactly one accepted cycle (bmem_ready=1), then go to RD_DATA; hold while bmem_ready=0.
REQ-014 SHALL in RD_DATA capture bmem_rdata into beat slot [cnt] on each bmem_rvalid with bmem_raddr equal to the line address; beat 0 occupies ufp_rdata[63:0].
REQ-015 SHALL ignore bmem_rvalid beats whose bmem_raddr mismatches.
REQ-016 SHALL go to RESP after the 4th accepted beat; cnt is 2 bits and wraps to 0.
REQ-017 SHALL in WR_DATA drive bmem_write with beat [cnt] of ufp_wdata, advance cnt only when bmem_ready=1, and go to RESP after beat 3 is accepted.
REQ-018 SHALL in RESP assert ufp_resp for exactly one cycle with ufp_rdata valid (reads), then return to IDLE.
REQ-019 SHALL require the dcache to hold ufp_* stable until ufp_resp; new requests are not sampled outside IDLE.
REQ-020 SHALL give read latency = 1 cycle after the 4th beat, write latency = 1 cycle after the last accepted beat.

Reset
REQ-021 SHALL on rst=0 immediately force state IDLE, cnt 0, ufp_resp 0, bmem_read 0, bmem_write 0, ufp_rdata 0, bmem_addr 0, bmem_wdata 0.
REQ-022 SHALL on reset mid-burst discard partial beats; the next request starts at beat 0.

Configuration
REQ-023 SHALL with CACHELINE_ADAPTER_LINEBUF_EN defined hold a one-entry line buffer (tag, valid, 256-bit data) filled by every completed read.
REQ-024 SHALL with the macro, on a read in IDLE hitting the buffer, skip DRAM and assert ufp_resp the next cycle with buffered data.
REQ-025 SHALL with the macro, on a write to the buffered line, update buffer data with ufp_wdata; buffer valid clears on reset.
REQ-026 SHALL without the macro issue every read to DRAM, with no buffer state.

Structure
REQ-027 SHALL place the state enum and BEATS/beat-index constants in lsu_types; widths come from cpu_params.
REQ-028 SHALL be a single module; no sub-module is natural.

Verification
REQ-029 SHALL cover read 0x1000_0020, bmem_ready=1, beats A0..A3 on consecutive cycles -> one bmem_read pulse at 0x1000_0020, ufp_resp 1 cycle after A3, ufp_rdata={A3,A2,A1,A0}.
REQ-030 SHALL cover write 0x2000_0047, wdata W, bmem_ready low on beat 2 for 3 cycles -> bmem_addr 0x2000_0040, beats W[63:0]..W[255:192] in order, beat 2 held 4 cycles, ufp_resp once.
REQ-031 SHALL cover read with interleaved rvalid at raddr 0x3000_0000 while waiting on 0x1000_0000 -> stray beat ignored, rdata built only from matching beats.
REQ-032 SHALL cover rst=0 after 2 read beats, then a new read -> all outputs 0 during reset, new burst fills from beat 0.
REQ-033 SHALL cover (LINEBUF_EN) two reads to 0x1000_0020 -> second completes in 1 cycle with no bmem_read; after a write to that line, a third read returns the written data.
REQ-034 SHALL cover read and write asserted together in IDLE -> write burst issued, no bmem_read.
